// File: rtl/usbh_report_arbiter.sv
// Shares one report decoder between two USB HID ports.
// Each port assembles up to 8 bytes into a 64-bit report. A completed report is parked in a
// per-port holding buffer (newest wins). A round-robin arbiter issues held reports to the
// decoder with a one-cycle strobe and captures the decoder's button output two edges later.
// A per-port watchdog drops the link state when no report completes for TIMEOUT_CYCLES.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_pN_data/valid/last      report byte stream of port N (N = 0, 1)
//   o_report, o_report_valid  report and strobe to the shared decoder
//   i_btn                     decoder button result, valid on the cycle after the strobe
//   o_btnN, o_connectedN      per-port button state and link-alive flag
module usbh_report_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_p0_data,
  input  logic        i_p0_valid,
  input  logic        i_p0_last,
  input  logic [7:0]  i_p1_data,
  input  logic        i_p1_valid,
  input  logic        i_p1_last,
  output logic [63:0] o_report,
  output logic        o_report_valid,
  input  logic [11:0] i_btn,
  output logic [11:0] o_btn0,
  output logic [11:0] o_btn1,
  output logic        o_connected0,
  output logic        o_connected1
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e                 state_q, state_d;
  logic [1:0][3:0]        cnt_q, cnt_d;
  logic [1:0][63:0]       asm_q, asm_d;
  logic [1:0][63:0]       hold_q, hold_d;
  logic [1:0]             pend_q, pend_d;
  logic [1:0][WdW-1:0]    wdog_q, wdog_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_q, grant_d;
  logic [63:0]            report_q, report_d;
  logic                   report_valid_q, report_valid_d;
  logic [1:0][11:0]       btn_q, btn_d;
  logic [1:0]             conn_q, conn_d;

  logic [1:0][7:0]        in_data;
  logic [1:0]             in_valid, in_last;
  logic [1:0]             done;
  logic [1:0][63:0]       done_buf;
  logic [1:0]             pend_clr;
  logic [1:0]             cap;
  logic                   g;

  assign in_data  = {i_p1_data, i_p0_data};
  assign in_valid = {i_p1_valid, i_p0_valid};
  assign in_last  = {i_p1_last, i_p0_last};

  // Byte assemblers: done_buf is the assembly buffer including this cycle's byte.
  always_comb begin
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    done     = '0;
    done_buf = asm_q;
    for (int p = 0; p < 2; p++) begin
      if (in_valid[p]) begin
        if (cnt_q[p] < 4'd8) begin
          done_buf[p][{cnt_q[p][2:0], 3'b000} +: 8] = in_data[p];
          cnt_d[p] = cnt_q[p] + 4'd1;
        end
        if (in_last[p]) begin
          done[p]  = 1'b1;
          cnt_d[p] = '0;
          asm_d[p] = '0;
        end else begin
          asm_d[p] = done_buf[p];
        end
      end
    end
  end

  // Arbiter / issue FSM.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    report_d       = report_q;
    report_valid_d = 1'b0;
    pend_clr       = '0;
    cap            = '0;
    g              = 1'b0;
    case (state_q)
      StIdle: begin
        if (|pend_q) begin
          g              = (pend_q[0] && pend_q[1]) ? ~last_grant_q : pend_q[1];
          grant_d        = g;
          last_grant_d   = g;
          report_d       = hold_q[g];
          pend_clr[g]    = 1'b1;
          report_valid_d = 1'b1;
          state_d        = StIssue;
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: begin
        cap[grant_q] = 1'b1;
        state_d      = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Pending, watchdog and per-port outputs. A completion on the grant edge keeps pending set.
  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    wdog_d = wdog_q;
    btn_d  = btn_q;
    conn_d = conn_q;
    for (int p = 0; p < 2; p++) begin
      pend_d[p] = done[p] | (pend_q[p] & ~pend_clr[p]);
      if (done[p]) begin
        hold_d[p] = done_buf[p];
        wdog_d[p] = '0;
      end else if (wdog_q[p] != WdMax) begin
        wdog_d[p] = wdog_q[p] + WdW'(1);
      end
      // Capture takes priority over the timeout clear.
      if (cap[p]) begin
        btn_d[p]  = i_btn;
        conn_d[p] = 1'b1;
      end else if (wdog_d[p] == WdMax) begin
        btn_d[p]  = '0;
        conn_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      asm_q          <= '0;
      hold_q         <= '0;
      pend_q         <= '0;
      wdog_q         <= '0;
      last_grant_q   <= 1'b1;
      grant_q        <= 1'b0;
      report_q       <= '0;
      report_valid_q <= 1'b0;
      btn_q          <= '0;
      conn_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      asm_q          <= asm_d;
      hold_q         <= hold_d;
      pend_q         <= pend_d;
      wdog_q         <= wdog_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      report_q       <= report_d;
      report_valid_q <= report_valid_d;
      btn_q          <= btn_d;
      conn_q         <= conn_d;
    end
  end

  assign o_report       = report_q;
  assign o_report_valid = report_valid_q;
  assign o_btn0         = btn_q[0];
  assign o_btn1         = btn_q[1];
  assign o_connected0   = conn_q[0];
  assign o_connected1   = conn_q[1];

endmodule

// File: doc/usbh_report_arbiter.md
USBH_REPORT_ARBITER -- requirements
Module: usbh_report_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1200000, meaning cycles without a completed report before a port is declared disconnected (min 4).
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_pN_data  input  8, i_pN_valid  input  1, i_pN_last  input  1 (N=0,1); these carry one report byte per valid cycle, and last marks the final byte of a report.
REQ-005 SHALL have port o_report  output  64  report presented to the shared decoder; byte n occupies bits [8n+7:8n].
REQ-006 SHALL have port o_report_valid  output  1  one-cycle strobe to the shared decoder.
REQ-007 SHALL have port i_btn  input  12  decoder button output, registered by the decoder on the o_report_valid cycle.
REQ-008 SHALL have ports o_btn0, o_btn1  output  12  per-port button state.
REQ-009 SHALL have ports o_connected0, o_connected1  output  1  per-port link alive.

Function
REQ-010 SHALL contain a per-port assembler: byte counter 0..8, 64-bit assembly buffer zeroed at reset and after each completed report.
REQ-011 SHALL write an accepted byte (valid=1) to assembly byte [counter] when counter<8, and SHALL drop bytes 9 and later without error.
REQ-012 SHALL, on an accepted byte with last=1, copy the assembly buffer including that byte to the port holding buffer and set port pending; unfilled bytes read as 0.
REQ-013 SHALL, when a new report completes while pending is already set, overwrite the holding buffer (newest wins); only one pending report per port.
REQ-014 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> IDLE; reset state IDLE.
REQ-015 SHALL, in IDLE with any pending: grant one port, register its holding buffer into o_report, clear its pending, record the grant, and go to ISSUE; with none pending, stay in IDLE.
REQ-016 SHALL, when both ports are pending, grant the port not granted last (round robin); last_grant resets to 1 so port 0 wins first.
REQ-017 SHALL, when a completion for the granted port coincides with the grant edge, leave pending set (set wins) with the new holding data.
REQ-018 SHALL assert o_report_valid only in ISSUE, exactly one cycle, with o_report stable from ISSUE until the next grant.
REQ-019 SHALL, in CAPTURE, load i_btn into o_btn of the granted port and set its o_connected.
REQ-020 SHALL give a latency of 3 clock edges, when idle, from the last-byte edge to o_btnN updating; throughput of at most one report per 3 cycles.
REQ-021 SHALL keep a per-port watchdog counter that clears on each completed report, otherwise increments and saturates at TIMEOUT_CYCLES.
REQ-022 SHALL, when the watchdog equals TIMEOUT_CYCLES, drive o_connectedN=0 and o_btnN=0; if CAPTURE for that port occurs in the same cycle, capture wins.
REQ-023 SHALL keep port assemblers independent; simultaneous bytes on both ports are both accepted.

Reset
REQ-024 SHALL, on reset, clear all counters, buffers, pending flags, watchdogs, o_report, o_report_valid, o_btn0/1 and o_connected0/1 to 0, set last_grant=1, and set FSM=IDLE.
REQ-025 SHALL, on reset mid-report or mid-FSM, discard the partial report and emit no strobe in the following cycle.

Verification
REQ-026 SHALL be verified with: port0 sends bytes 00,FF,01 (last) -> o_report=64'h0000_0000_0001_FF00, one o_report_valid pulse, and o_btn0=i_btn 3 edges after last, with o_connected0=1.
REQ-027 SHALL be verified with: both ports complete in the same cycle -> port0 issued first, then port1 3 cycles later; repeating the case gives port0, port1 alternation.
REQ-028 SHALL be verified with: a 10-byte report 11..1A -> o_report=64'h1817_1615_1413_1211, extra bytes dropped, next report starts at byte 0.
REQ-029 SHALL be verified with: TIMEOUT_CYCLES=16, port1 completes once and then stays silent -> o_connected1=0 and o_btn1=0 exactly 16 cycles after the completion edge; port0 is unaffected.
REQ-030 SHALL be verified with: two reports on port0 before its grant -> only the second is issued, as a single strobe.
REQ-031 SHALL be verified with: reset asserted after 3 bytes of a report -> no strobe; the next 2-byte report AA,BB -> o_report=64'hBBAA.
